conv_mac_sequencer: RTL and testbench
=====================================

# conv_mac_sequencer

Sequencer for the convolution MAC datapath. Owns the circular x-memory write pointer. Once x-memory holds F_SIZE samples and the filter is loaded, it issues F_SIZE tap reads to x-memory and f-memory and drives the accumulator enables. When y[k] is final it raises `conv_start` toward the x-memory/output controller, then waits for the output handshake and the next x sample before computing y[k+1].

## Interface
- `X_MEM_ADDR_WIDTH`, 5: x/f memory address width; `F_SIZE` must equal 2**X_MEM_ADDR_WIDTH.
- `X_SIZE`, 128: input samples per convolution; outputs per run = X_SIZE-F_SIZE+1.
- `F_SIZE`, 32: filter taps.
- `MAC_LAT`, 1 (≥1): cycles from the last `mac_en` cycle until the accumulator output is final.

- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `xmem_wr_en`  in  1  x-memory write strobe from the xmem/output controller.
- `xmem_full`  in  1  F_SIZE samples present.
- `f_loaded`  in  1  filter memory loaded (level).
- `out_accept`  in  1  output handshake, m_valid && m_ready.
- `conv_done`  in  1  one-cycle pulse, run finished.
- `xmem_wr_addr`  out  X_MEM_ADDR_WIDTH  x-memory write address.
- `xmem_rd_addr`  out  X_MEM_ADDR_WIDTH  x-memory read address.
- `fmem_rd_addr`  out  X_MEM_ADDR_WIDTH  f-memory read address.
- `rd_en`  out  1  read strobe for both memories.
- `mac_en`  out  1  accumulate product this cycle.
- `acc_clear`  out  1  with `mac_en`: load the product and discard the old sum.
- `conv_start`  out  1  y[k] final in the accumulator (level).
- `y_idx`  out  $clog2(X_SIZE)  index k of the current output.
- `seq_err`  out  1  sticky protocol-violation flag.

## Operation
- All outputs are registered. Reset values: every output 0; state IDLE; tap counter 0; drain counter 0.
- `xmem_wr_addr` increments modulo F_SIZE on every `xmem_wr_en`, in every state. When x-memory is full, `xmem_wr_addr` points at the oldest sample (base).
- y[k] = Σ_{j=0..F_SIZE-1} x[base+j mod F_SIZE] · f[j].
- States:
  - IDLE: wait for `xmem_full && f_loaded`, then go to COMPUTE.
  - COMPUTE: tap counter j = 0..F_SIZE-1, one tap per cycle. Drive `rd_en`=1, `xmem_rd_addr`=(base+j) mod F_SIZE, `fmem_rd_addr`=j. After j=F_SIZE-1, go to DRAIN.
  - DRAIN: hold for MAC_LAT cycles, then go to READY.
  - READY: `conv_start`=1.
    - `out_accept` with `xmem_wr_en` in the same cycle: increment `y_idx` and go to COMPUTE.
    - `out_accept` alone: increment `y_idx` and go to WAIT_X.
  - WAIT_X: on `xmem_wr_en`, go to COMPUTE.
- `conv_done` has highest priority from any state. The next state is IDLE, with `xmem_wr_addr`, `y_idx` and `conv_start` cleared on the following edge. `seq_err` is not cleared (reset only).
- Memory read latency is fixed at 1 cycle. `mac_en` is `rd_en` delayed by 1 cycle. `acc_clear` is high together with `mac_en` only for tap 0.
- `seq_err` sets on any of:
  - `xmem_wr_en` in COMPUTE or DRAIN (the base moves mid-sum; the write address still advances);
  - `out_accept` outside READY;
  - `f_loaded` low in COMPUTE.
- Address arithmetic is modulo 2**X_MEM_ADDR_WIDTH; wrap at F_SIZE-1 → 0 is natural overflow.
- Reset mid-operation: abandon the sum, return to IDLE with all outputs 0 on the next edge.

## Timing
- COMPUTE entered at edge c0:
  - `rd_en` high during cycles c0..c0+F_SIZE-1;
  - `mac_en` high during c0+1..c0+F_SIZE;
  - `acc_clear` high during c0+1 only;
  - `conv_start` high from c0+F_SIZE+MAC_LAT.
- Latency from COMPUTE entry to `conv_start` = F_SIZE+MAC_LAT cycles (33 at defaults).
- `conv_start` drops on the edge after `out_accept`. There are no back-to-back READY cycles after acceptance.
- Same-cycle `out_accept` and `xmem_wr_en` in READY: COMPUTE starts on the next edge using the updated base (old base + 1).
- In the first COMPUTE after fill, base = 0.

## Test plan
- Reset, then 32 writes with `f_loaded`=1, `xmem_full`=1 → COMPUTE starts the next cycle.
  - `xmem_rd_addr` runs 0..31; `acc_clear` only on the first `mac_en`; `conv_start` rises 33 cycles after COMPUTE entry.
- READY with `out_accept` and `xmem_wr_en` in the same cycle → next COMPUTE reads x addresses 1..31,0; `y_idx`=1; `conv_start` low for exactly 33 cycles.
- `out_accept`, then `xmem_wr_en` 5 cycles later → WAIT_X for 5 cycles, then COMPUTE; `rd_en` stays low while waiting.
- Full run, X_SIZE=128 → 97 `conv_start` assertions; `y_idx` ends at 97. The `conv_done` pulse → IDLE with `xmem_wr_addr`=0, `y_idx`=0.
- `xmem_wr_en` at tap 10 of COMPUTE → `seq_err`=1 the next cycle and stays 1 until `reset`; `xmem_wr_addr` still increments.
- `reset` asserted at tap 20 → next cycle all outputs 0, state IDLE; the following fill behaves as in the first scenario.

Source files
------------

// File: rtl/conv_mac_sequencer.sv
// Sequencer for the convolution MAC: owns the circular x-memory write pointer and issues F_SIZE tap reads per output.
// Latency: COMPUTE entry to conv_start is F_SIZE+MAC_LAT cycles; waits in READY for out_accept and in WAIT_X for a fresh sample.
module conv_mac_sequencer #(
  parameter int X_MEM_ADDR_WIDTH = 5,
  parameter int X_SIZE           = 128,
  parameter int F_SIZE           = 32,
  parameter int MAC_LAT          = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        xmem_wr_en,
  input  logic                        xmem_full,
  input  logic                        f_loaded,
  input  logic                        out_accept,
  input  logic                        conv_done,
  output logic [X_MEM_ADDR_WIDTH-1:0] xmem_wr_addr,
  output logic [X_MEM_ADDR_WIDTH-1:0] xmem_rd_addr,
  output logic [X_MEM_ADDR_WIDTH-1:0] fmem_rd_addr,
  output logic                        rd_en,
  output logic                        mac_en,
  output logic                        acc_clear,
  output logic                        conv_start,
  output logic [$clog2(X_SIZE)-1:0]   y_idx,
  output logic                        seq_err
);

  localparam int AW = X_MEM_ADDR_WIDTH;
  localparam int YW = $clog2(X_SIZE);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0] LAST_TAP   = AW'(F_SIZE - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, COMPUTE, DRAIN, READY, WAIT_X} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   tap_cnt, tap_nxt;
  logic [DW-1:0]   drain_cnt, drain_nxt;
  logic [AW-1:0]   wr_addr_nxt, rd_addr_nxt;
  logic [YW-1:0]   y_idx_nxt;
  logic            err;

  always_comb begin
    state_nxt   = state;
    tap_nxt     = tap_cnt;
    drain_nxt   = '0;
    rd_addr_nxt = xmem_rd_addr;
    y_idx_nxt   = y_idx;
    wr_addr_nxt = xmem_wr_en ? xmem_wr_addr + AW'(1) : xmem_wr_addr;

    case (state)
      IDLE: begin
        if (xmem_full && f_loaded) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (tap_cnt == LAST_TAP) begin
          state_nxt = DRAIN;
        end else begin
          tap_nxt     = tap_cnt + AW'(1);
          rd_addr_nxt = xmem_rd_addr + AW'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == LAST_DRAIN) state_nxt = READY;
        else                         drain_nxt = drain_cnt + DW'(1);
      end
      READY: begin
        if (out_accept) begin
          y_idx_nxt = y_idx + YW'(1);
          state_nxt = xmem_wr_en ? COMPUTE : WAIT_X;
        end
      end
      WAIT_X: begin
        if (xmem_wr_en) state_nxt = COMPUTE;
      end
      default: state_nxt = IDLE;
    endcase

    // Base for a new sum is the write pointer after this cycle's write, i.e. the oldest sample.
    if (state != COMPUTE && state_nxt == COMPUTE) begin
      tap_nxt     = '0;
      rd_addr_nxt = wr_addr_nxt;
    end

    if (conv_done) begin
      state_nxt   = IDLE;
      wr_addr_nxt = '0;
      y_idx_nxt   = '0;
    end

    err = (xmem_wr_en && (state == COMPUTE || state == DRAIN)) ||
          (out_accept && state != READY) ||
          (!f_loaded && state == COMPUTE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tap_cnt      <= '0;
      drain_cnt    <= '0;
      xmem_wr_addr <= '0;
      xmem_rd_addr <= '0;
      fmem_rd_addr <= '0;
      rd_en        <= 1'b0;
      mac_en       <= 1'b0;
      acc_clear    <= 1'b0;
      conv_start   <= 1'b0;
      y_idx        <= '0;
      seq_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      tap_cnt      <= tap_nxt;
      drain_cnt    <= drain_nxt;
      xmem_wr_addr <= wr_addr_nxt;
      xmem_rd_addr <= rd_addr_nxt;
      fmem_rd_addr <= tap_nxt;
      rd_en        <= (state_nxt == COMPUTE);
      // Memory read latency is one cycle, so the MAC follows the read strobe by one.
      mac_en       <= rd_en;
      acc_clear    <= rd_en && (fmem_rd_addr == '0);
      conv_start   <= (state_nxt == READY);
      y_idx        <= y_idx_nxt;
      seq_err      <= seq_err | err;
    end
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer: stimulus pushes expected taps/outputs into queues, a monitor pops and compares.
module tb_conv_mac_sequencer;

  localparam int AW = 5;
  localparam int F  = 32;
  localparam int LAT_EXP = 33;

  logic       clk = 1'b0;
  logic       reset, xmem_wr_en, xmem_full, f_loaded, out_accept, conv_done;
  logic [4:0] xmem_wr_addr, xmem_rd_addr, fmem_rd_addr;
  logic       rd_en, mac_en, acc_clear, conv_start, seq_err;
  logic [6:0] y_idx;

  conv_mac_sequencer #(.X_MEM_ADDR_WIDTH(5), .X_SIZE(128), .F_SIZE(32), .MAC_LAT(1)) dut (
    .clk(clk), .reset(reset), .xmem_wr_en(xmem_wr_en), .xmem_full(xmem_full),
    .f_loaded(f_loaded), .out_accept(out_accept), .conv_done(conv_done),
    .xmem_wr_addr(xmem_wr_addr), .xmem_rd_addr(xmem_rd_addr), .fmem_rd_addr(fmem_rd_addr),
    .rd_en(rd_en), .mac_en(mac_en), .acc_clear(acc_clear), .conv_start(conv_start),
    .y_idx(y_idx), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int c0 = 0;
  int n_start = 0;
  logic rd_prev = 1'b0;
  logic cs_prev = 1'b0;

  logic [9:0] tap_q[$];
  bit         mac_q[$];
  int         out_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_compute(input int base, input int y);
    for (int j = 0; j < F; j++) begin
      tap_q.push_back({AW'((base + j) % F), AW'(j)});
      mac_q.push_back(j == 0);
    end
    out_q.push_back(y);
  endtask

  // Monitor: compares every read, every MAC cycle and every conv_start rise against the queues.
  always @(negedge clk) begin
    if (rd_en) begin
      if (tap_q.size() == 0) chk("rd_unexpected", 32'(rd_en), 0);
      else chk("rd_addr", 32'({xmem_rd_addr, fmem_rd_addr}), 32'(tap_q.pop_front()));
    end
    if (mac_en) begin
      if (mac_q.size() == 0) chk("mac_unexpected", 32'(mac_en), 0);
      else chk("acc_clear", 32'(acc_clear), 32'(mac_q.pop_front()));
    end else if (acc_clear) begin
      chk("acc_clear_without_mac", 32'(acc_clear), 0);
    end
    if (rd_en && !rd_prev) c0 = cyc;
    if (conv_start && !cs_prev) begin
      n_start++;
      chk("start_latency", 32'(cyc - c0), LAT_EXP);
      if (out_q.size() == 0) chk("start_unexpected", 32'(conv_start), 0);
      else chk("y_idx", 32'(y_idx), 32'(out_q.pop_front()));
    end
    rd_prev = rd_en;
    cs_prev = conv_start;
  end

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      xmem_wr_en = 1'b1;
      @(negedge clk);
    end
    xmem_wr_en = 1'b0;
  endtask

  task automatic wait_start();
    int t = 0;
    while (!conv_start && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!conv_start) chk("start_timeout", 32'(conv_start), 1);
  endtask

  task automatic accept(input bit with_wr);
    out_accept = 1'b1;
    xmem_wr_en = with_wr;
    @(negedge clk);
    out_accept = 1'b0;
    xmem_wr_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_addr"}, 32'(xmem_wr_addr), 0);
    chk({tag, "_rd_addr"}, 32'(xmem_rd_addr), 0);
    chk({tag, "_f_addr"}, 32'(fmem_rd_addr), 0);
    chk({tag, "_strobes"}, 32'({rd_en, mac_en, acc_clear, conv_start}), 0);
    chk({tag, "_y_idx"}, 32'(y_idx), 0);
    chk({tag, "_seq_err"}, 32'(seq_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; xmem_wr_en = 1'b0; xmem_full = 1'b0; f_loaded = 1'b1;
    out_accept = 1'b0; conv_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Fill, then first sum from base 0.
    write_n(32);
    chk("fill_wr_addr", 32'(xmem_wr_addr), 0);
    push_compute(0, 0);
    xmem_full = 1'b1;
    @(negedge clk);
    chk("compute_start", 32'(rd_en), 1);
    wait_start();

    // Accept and write together: next sum uses base 1 immediately.
    push_compute(1, 1);
    accept(1'b1);
    chk("start_drop", 32'(conv_start), 0);
    chk("wr_addr_after_write", 32'(xmem_wr_addr), 1);
    wait_start();

    // Accept alone, sample arrives 5 cycles later.
    accept(1'b0);
    chk("y_idx_after_accept", 32'(y_idx), 2);
    for (int i = 0; i < 5; i++) begin
      chk("wait_x_rd_en", 32'({rd_en, conv_start}), 0);
      @(negedge clk);
    end
    push_compute(2, 2);
    write_n(1);
    wait_start();

    for (int k = 2; k < 96; k++) begin
      push_compute((k + 1) % F, k + 1);
      accept(1'b1);
      wait_start();
    end
    accept(1'b0);
    chk("y_idx_end", 32'(y_idx), 97);
    chk("start_count", 32'(n_start), 97);
    conv_done = 1'b1;
    xmem_full = 1'b0;
    @(negedge clk);
    conv_done = 1'b0;
    chk("done_wr_addr", 32'(xmem_wr_addr), 0);
    chk("done_y_idx", 32'(y_idx), 0);
    chk("done_conv_start", 32'(conv_start), 0);
    chk("done_seq_err", 32'(seq_err), 0);

    // Write during COMPUTE flags an error; reset at tap 20 aborts the sum.
    write_n(32);
    push_compute(0, 0);
    xmem_full = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    xmem_wr_en = 1'b1;
    @(negedge clk);
    xmem_wr_en = 1'b0;
    chk("seq_err_set", 32'(seq_err), 1);
    chk("seq_err_wr_addr", 32'(xmem_wr_addr), 1);
    repeat (9) @(negedge clk);
    chk("seq_err_sticky", 32'(seq_err), 1);
    chk("tap20_rd_addr", 32'(xmem_rd_addr), 20);
    reset = 1'b1;
    xmem_full = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tap_q.delete();
    mac_q.delete();
    out_q.delete();
    chk_all_zero("midreset");
    @(negedge clk);
    chk("idle_after_reset", 32'(rd_en), 0);

    // out_accept outside READY is a protocol error.
    out_accept = 1'b1;
    @(negedge clk);
    out_accept = 1'b0;
    chk("accept_err", 32'(seq_err), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("err_cleared", 32'(seq_err), 0);

    // Refill after reset behaves like the first run.
    write_n(32);
    push_compute(0, 0);
    xmem_full = 1'b1;
    @(negedge clk);
    chk("refill_compute_start", 32'(rd_en), 1);
    wait_start();
    @(negedge clk);

    chk("tap_q_empty", 32'(tap_q.size()), 0);
    chk("mac_q_empty", 32'(mac_q.size()), 0);
    chk("out_q_empty", 32'(out_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
